// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data access.
// Each access holds the port for WAIT_CYCLES+1 cycles, then pulses the owner's ack for one cycle.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ack,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              owner_q, owner_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              grant_data;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        owner_d    = owner_q;
        last_d     = last_q;
        rdata_d    = rdata_q;
        grant_data = 1'b0;
        case (state_q)
            IDLE: begin
                if (fetch_req || data_req) begin
                    // On a tie the requester that did not own the last access wins.
                    grant_data = data_req && (!fetch_req || !last_q);
                    state_d    = ACCESS;
                    cnt_d      = WAIT_INIT;
                    addr_d     = grant_data ? data_addr : fetch_addr;
                    we_d       = grant_data && data_we;
                    wdata_d    = data_wdata;
                    owner_d    = grant_data;
                    last_d     = grant_data;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Port signals come straight from the latched request so they stay stable through ACCESS.
    assign mem_en    = (state_q == ACCESS);
    assign mem_we    = (state_q == ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign fetch_ack = (state_q == RESP) && !owner_q;
    assign data_ack  = (state_q == RESP) && owner_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: scoreboard of expected accesses checked at each ack,
// plus WAIT_CYCLES=0 and WAIT_CYCLES=3 instances for latency and port-width checks.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int W = 1;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [15:0] fetch_addr = '0;
    logic        data_req = 1'b0;
    logic        data_we = 1'b0;
    logic [15:0] data_addr = '0;
    logic [15:0] data_wdata = '0;
    logic [15:0] mem_rdata = '0;
    logic        fetch_ack, data_ack, mem_en, mem_we, busy, owner;
    logic [15:0] rdata, mem_addr, mem_wdata;

    logic        req_x = 1'b0;
    logic        zero_l = 1'b0;
    logic [15:0] zero16 = '0;
    logic        fa0, da0, en0, we0, busy0, own0;
    logic [15:0] rd0, ma0, mw0;
    logic        fa3, da3, en3, we3, busy3, own3;
    logic [15:0] rd3, ma3, mw3;

    always #5 CLK = ~CLK;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(W)) dut (
        .CLK(CLK), .Reset(Reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_ack(data_ack), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(0)) dut_w0 (
        .CLK(CLK), .Reset(Reset),
        .fetch_req(req_x), .fetch_addr(fetch_addr), .fetch_ack(fa0),
        .data_req(zero_l), .data_we(zero_l), .data_addr(zero16),
        .data_wdata(zero16), .data_ack(da0), .rdata(rd0),
        .mem_en(en0), .mem_we(we0), .mem_addr(ma0), .mem_wdata(mw0),
        .mem_rdata(mem_rdata), .busy(busy0), .owner(own0)
    );

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(3)) dut_w3 (
        .CLK(CLK), .Reset(Reset),
        .fetch_req(req_x), .fetch_addr(fetch_addr), .fetch_ack(fa3),
        .data_req(zero_l), .data_we(zero_l), .data_addr(zero16),
        .data_wdata(zero16), .data_ack(da3), .rdata(rd3),
        .mem_en(en3), .mem_we(we3), .mem_addr(ma3), .mem_wdata(mw3),
        .mem_rdata(mem_rdata), .busy(busy3), .owner(own3)
    );

    typedef struct {
        logic        owner;
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } txn_t;

    txn_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic o, input logic [15:0] a, input logic we,
                        input logic [15:0] wd, input logic [15:0] rd);
        txn_t t;
        t.owner = o;
        t.addr  = a;
        t.we    = we;
        t.wdata = wd;
        t.rdata = rd;
        sb.push_back(t);
    endtask

    task automatic chk_reset_outs(input string p);
        chk({p, "_fetch_ack"}, fetch_ack, 0);
        chk({p, "_data_ack"}, data_ack, 0);
        chk({p, "_rdata"}, rdata, 0);
        chk({p, "_mem_en"}, mem_en, 0);
        chk({p, "_mem_we"}, mem_we, 0);
        chk({p, "_mem_addr"}, mem_addr, 0);
        chk({p, "_mem_wdata"}, mem_wdata, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_owner"}, owner, 0);
    endtask

    // Serve the transaction at the head of the scoreboard; exp_lat counts ticks to the ack.
    task automatic serve(input int exp_lat, input bit chg);
        txn_t t;
        int   en_cnt = 0;
        bit   done = 1'b0;
        t = sb[0];
        for (int c = 1; c <= 12 && !done; c++) begin
            mem_rdata = t.rdata;
            tick();
            if (chg && c == 1) begin
                fetch_addr = 16'hFFFF;
                fetch_req  = 1'b0;
            end
            chk("mem_en_window", mem_en, (c >= exp_lat - W - 1) && (c <= exp_lat - 1));
            chk("busy_window", busy, (c >= exp_lat - W - 1) && (c <= exp_lat));
            if (mem_en) begin
                en_cnt++;
                chk("mem_addr", mem_addr, t.addr);
                chk("mem_we", mem_we, t.we);
                if (t.we) chk("mem_wdata", mem_wdata, t.wdata);
            end
            chk("ack_both", fetch_ack & data_ack, 0);
            if (fetch_ack || data_ack) begin
                done = 1'b1;
                chk("ack_latency", c, exp_lat);
                chk("ack_owner", data_ack, t.owner);
                chk("owner", owner, t.owner);
                chk("mem_en_width", en_cnt, W + 1);
                if (!t.we) exp_rdata = t.rdata;
                chk("rdata", rdata, exp_rdata);
                if (t.owner) data_req = 1'b0;
                else fetch_req = 1'b0;
                t = sb.pop_front();
            end else begin
                chk("rdata_hold", rdata, exp_rdata);
            end
        end
        chk("ack_seen", done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int en0_cnt, en3_cnt, ack0_t, ack3_t, ack0_n, ack3_n;

        // Reset state
        #2 Reset = 1'b0;
        #1 chk_reset_outs("rst");
        @(negedge CLK) Reset = 1'b1;
        tick();

        // Single fetch
        push(1'b0, 16'h0010, 1'b0, 16'h0000, 16'hA5C3);
        fetch_addr = 16'h0010;
        fetch_req  = 1'b1;
        serve(3, 1'b0);
        tick();

        // Store leaves rdata alone even though the memory drives a value
        push(1'b1, 16'h0200, 1'b1, 16'h1234, 16'hDEAD);
        data_addr  = 16'h0200;
        data_wdata = 16'h1234;
        data_we    = 1'b1;
        data_req   = 1'b1;
        serve(3, 1'b0);
        tick();

        // Simultaneous fetch and load, twice back to back: F, D, F, D
        push(1'b0, 16'h0004, 1'b0, 16'h0000, 16'h1111);
        push(1'b1, 16'h0300, 1'b0, 16'h0000, 16'h2222);
        fetch_addr = 16'h0004;
        data_addr  = 16'h0300;
        data_we    = 1'b0;
        fetch_req  = 1'b1;
        data_req   = 1'b1;
        serve(3, 1'b0);
        serve(4, 1'b0);
        push(1'b0, 16'h0004, 1'b0, 16'h0000, 16'h3333);
        push(1'b1, 16'h0300, 1'b0, 16'h0000, 16'h4444);
        fetch_req = 1'b1;
        data_req  = 1'b1;
        serve(4, 1'b0);
        serve(4, 1'b0);
        tick();

        // After a fetch-only access, a tie goes to data
        push(1'b0, 16'h0008, 1'b0, 16'h0000, 16'h5555);
        fetch_addr = 16'h0008;
        fetch_req  = 1'b1;
        serve(3, 1'b0);
        tick();
        push(1'b1, 16'h0310, 1'b0, 16'h0000, 16'h6666);
        push(1'b0, 16'h000C, 1'b0, 16'h0000, 16'h7777);
        data_addr  = 16'h0310;
        fetch_addr = 16'h000C;
        data_req   = 1'b1;
        fetch_req  = 1'b1;
        serve(3, 1'b0);
        serve(4, 1'b0);
        tick();

        // Requester inputs change mid-access
        push(1'b0, 16'h0020, 1'b0, 16'h0000, 16'h8888);
        fetch_addr = 16'h0020;
        fetch_req  = 1'b1;
        serve(3, 1'b1);
        tick();

        // Reset during the second ACCESS cycle
        fetch_addr = 16'h0040;
        fetch_req  = 1'b1;
        mem_rdata  = 16'h9999;
        tick();
        tick();
        chk("pre_rst_mem_en", mem_en, 1);
        #2 Reset = 1'b0;
        #1 chk_reset_outs("midrst");
        fetch_req = 1'b0;
        exp_rdata = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("midrst_no_ack", fetch_ack | data_ack, 0);
            chk("midrst_busy", busy, 0);
        end
        @(negedge CLK) Reset = 1'b1;
        tick();

        // First tie after reset goes to fetch, with standard latency
        push(1'b0, 16'h0050, 1'b0, 16'h0000, 16'hABCD);
        push(1'b1, 16'h0350, 1'b0, 16'h0000, 16'h1357);
        fetch_addr = 16'h0050;
        data_addr  = 16'h0350;
        fetch_req  = 1'b1;
        data_req   = 1'b1;
        serve(3, 1'b0);
        serve(4, 1'b0);
        tick();

        // WAIT_CYCLES=0 and WAIT_CYCLES=3 builds
        en0_cnt = 0; en3_cnt = 0; ack0_t = 0; ack3_t = 0; ack0_n = 0; ack3_n = 0;
        fetch_addr = 16'h0060;
        mem_rdata  = 16'h2468;
        req_x      = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (en0) begin
                en0_cnt++;
                chk("w0_mem_addr", ma0, 16'h0060);
                chk("w0_mem_we", we0, 0);
            end
            if (en3) begin
                en3_cnt++;
                chk("w3_mem_addr", ma3, 16'h0060);
                chk("w3_mem_we", we3, 0);
            end
            chk("w0_data_ack", da0, 0);
            chk("w3_data_ack", da3, 0);
            if (fa0) begin
                ack0_n++;
                ack0_t = c;
                req_x  = 1'b0;
            end
            if (fa3) begin
                ack3_n++;
                ack3_t = c;
            end
        end
        chk("w0_en_width", en0_cnt, 1);
        chk("w3_en_width", en3_cnt, 4);
        chk("w0_ack_latency", ack0_t, 2);
        chk("w3_ack_latency", ack3_t, 5);
        chk("w0_ack_count", ack0_n, 1);
        chk("w3_ack_count", ack3_n, 1);
        chk("w0_rdata", rd0, 16'h2468);
        chk("w3_rdata", rd3, 16'h2468);
        chk("w0_busy", busy0, 0);
        chk("w3_busy", busy3, 0);
        chk("w0_owner", own0, 0);
        chk("w3_owner", own3, 0);
        chk("w0_mem_wdata", mw0, 16'h0000);
        chk("w3_mem_wdata", mw3, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 16-bit memory port between two requesters: the instruction-fetch path (PC/IR side) and the data path (load/store side, MDR/ALUOut address).
- Sits between the multicycle control/datapath and the memory block.
- Sequences each access through a fixed wait-state count and returns a one-cycle acknowledge with registered read data, so the control FSM stalls on ack rather than assuming single-cycle memory.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
WAIT_CYCLES, 1, extra memory cycles per access (0..15); ACCESS lasts WAIT_CYCLES+1 cycles

Ports:
CLK  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-low reset
fetch_req  input  1  fetch requester wants a read; held until fetch_ack
fetch_addr  input  ADDR_W  fetch address
fetch_ack  output  1  one-cycle pulse: fetch access complete, rdata valid
data_req  input  1  data requester wants an access; held until data_ack
data_we  input  1  1 = store, 0 = load
data_addr  input  ADDR_W  data address
data_wdata  input  DATA_W  store data
data_ack  output  1  one-cycle pulse: data access complete (rdata valid if load)
rdata  output  DATA_W  registered read data of last completed read
mem_en  output  1  memory enable
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid in last ACCESS cycle
busy  output  1  high in ACCESS and RESP
owner  output  1  owner of the current or last transaction: 0 = fetch, 1 = data

Behaviour:
- Reset (Reset=0, async): state=IDLE, counter=0. All outputs 0: fetch_ack, data_ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy, owner. last_owner=1 (data), so fetch wins the first tie.
- States: IDLE, ACCESS, RESP.
- IDLE, decision at the rising edge:
  - Only fetch_req: grant fetch.
  - Only data_req: grant data.
  - Both: grant the requester that is not last_owner (round-robin).
  - Neither: stay in IDLE.
- On grant:
  - Latch addr; latch we (data grant: data_we; fetch grant: 0) and wdata.
  - Set owner and last_owner to the granted requester.
  - counter=WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - mem_en=1; mem_addr/mem_we/mem_wdata driven from the latched values and held constant for the whole state.
  - If counter != 0: decrement, stay in ACCESS.
  - If counter == 0: if latched we=0, capture mem_rdata into rdata; go to RESP.
- RESP:
  - mem_en=0, mem_we=0.
  - Assert ack of the owner for exactly this one cycle.
  - Requests are ignored; go to IDLE.
- Latency: a request sampled at edge t0 gives ACCESS for cycles t0+1..t0+WAIT_CYCLES+1 and ack at cycle t0+WAIT_CYCLES+2. Back-to-back minimum period is WAIT_CYCLES+3 cycles.
- Requesters drop req in the cycle after ack is seen. A req still high in IDLE is a new request.
- Requester input changes after grant are ignored until the next IDLE decision.
- A req deasserted mid-ACCESS does not abort: the access completes and ack is still pulsed.
- rdata holds its value across stores and idle cycles; it changes only on completion of a read.
- mem_addr and mem_wdata hold their last values outside ACCESS. Only mem_en and mem_we return to 0.
- busy = (state != IDLE).
- Reset asserted mid-ACCESS or mid-RESP: the transaction is abandoned immediately with no ack, and all outputs go to their reset values.
- Never both acks high in the same cycle. mem_we is never 1 for a fetch.

Test Plan:
- Single fetch, WAIT_CYCLES=1: fetch_req=1, fetch_addr=0x0010, mem_rdata=0xA5C3 -> mem_en high exactly 2 cycles with mem_addr=0x0010, mem_we=0; fetch_ack pulse 3 cycles after the sampling edge; rdata=0xA5C3; data_ack stays 0.
- Store: data_req=1, data_we=1, data_addr=0x0200, data_wdata=0x1234 -> mem_we=1, mem_addr=0x0200, mem_wdata=0x1234 for 2 cycles; data_ack pulse; rdata unchanged from its prior value.
- Simultaneous requests after reset: fetch (0x0004) and data load (0x0300) both held -> fetch served first, data second; owner goes 0 then 1. Repeat both requests -> order alternates fetch, data, fetch, data.
- Inputs change mid-access: after grant, change fetch_addr to 0xFFFF and drop fetch_req -> mem_addr stays at the latched value; access completes; fetch_ack still pulses once.
- Reset mid-op: assert Reset=0 during the second ACCESS cycle -> all outputs 0 asynchronously (before the next edge), no ack; after release, a new fetch completes normally with standard latency.
- WAIT_CYCLES=0 and WAIT_CYCLES=3 builds: mem_en width is 1 and 4 cycles; ack is 2 and 5 cycles after the sampling edge.
